// File: rtl/button_pkg.sv
// Shared defaults for the push-button front end, plus a helper that turns a
// debounce time in milliseconds into a count of sample ticks.
package button_pkg;

  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned TICK_DIV = 4096;

  // Whole ticks covering ms milliseconds, never less than one.
  function automatic int unsigned debounce_ticks_from_ms(
    input int unsigned ms,
    input int unsigned clk_hz,
    input int unsigned tick_div
  );
    logic [63:0] ticks;
    ticks = (64'(ms) * 64'(clk_hz)) / (64'(1000) * 64'(tick_div));
    return (ticks == 64'd0) ? 32'd1 : 32'(ticks);
  endfunction

  localparam int unsigned DEBOUNCE_TICKS      = debounce_ticks_from_ms(10, CLK_HZ, TICK_DIV);
  localparam int unsigned CHORD_LOCKOUT_TICKS = 16384;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser, tick-paced debounce counter,
// clean pressed level and single-cycle press/release strobes.
module debounce_chan #(
  parameter int unsigned DEBOUNCE_TICKS = button_pkg::DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic but_n,
  input  logic tick,
  output logic lvl,
  output logic press,
  output logic rel
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             sample;

  // Any cycle that agrees with the current level clears the run of differing ticks.
  always_comb begin
    sync1_d = but_n;
    sync2_d = sync1_q;
    sample  = ~sync2_q;
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sample != lvl_q) begin
      cnt_d = cnt_q;
      if (tick) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          lvl_d   = sample;
          press_d = sample;
          rel_d   = ~sample;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign lvl   = lvl_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: shared sample-tick prescaler, one debounce channel per
// button, and a rate-limited strobe when every button is held together.
module button_conditioner #(
  parameter int unsigned N_BUT               = 2,
  parameter int unsigned TICK_DIV            = button_pkg::TICK_DIV,
  parameter int unsigned DEBOUNCE_TICKS      = button_pkg::DEBOUNCE_TICKS,
  parameter int unsigned CHORD_LOCKOUT_TICKS = button_pkg::CHORD_LOCKOUT_TICKS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BUT-1:0] BUT_N,
  output logic [N_BUT-1:0] BUT_LVL,
  output logic [N_BUT-1:0] BUT_PRESS,
  output logic [N_BUT-1:0] BUT_RELEASE,
  output logic             CHORD,
  output logic             TICK
);

  localparam int unsigned DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LOCK_W = $clog2(CHORD_LOCKOUT_TICKS + 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              armed_q, armed_d;
  logic              chord_q, chord_d;
  logic              lock_full;

  // Prescaler: explicit wrap so non-power-of-two dividers work too.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    tick_d = 1'b0;
    if (div_q == DIV_W'(TICK_DIV - 1)) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
  end

  for (genvar i = 0; i < int'(N_BUT); i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_chan (
      .clk  (CLK),
      .rst  (RST),
      .but_n(BUT_N[i]),
      .tick (tick_q),
      .lvl  (BUT_LVL[i]),
      .press(BUT_PRESS[i]),
      .rel  (BUT_RELEASE[i])
    );
  end

  // Chord fires once per full hold; re-arming needs a full release and an expired lockout.
  always_comb begin
    lock_full = (lock_q == LOCK_W'(CHORD_LOCKOUT_TICKS));
    lock_d    = lock_q;
    armed_d   = armed_q;
    if (tick_q && !lock_full) begin
      lock_d = lock_q + LOCK_W'(1);
    end
    if (BUT_LVL == '0) begin
      armed_d = 1'b1;
    end
    chord_d = (&BUT_LVL) && armed_q && lock_full;
    if (chord_d) begin
      lock_d  = '0;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      lock_q  <= '0;
      armed_q <= 1'b1;
      chord_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      lock_q  <= lock_d;
      armed_q <= armed_d;
      chord_q <= chord_d;
    end
  end

  assign TICK  = tick_q;
  assign CHORD = chord_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: timestamp-based reference model plus directed
// and randomized scenarios with small tick/debounce/lockout constants.
module tb_button_conditioner;

  localparam int unsigned N_BUT = 2;
  localparam int unsigned TDIV  = 4;
  localparam int unsigned DEB   = 3;
  localparam int unsigned LOCK  = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [N_BUT-1:0] BUT_N = '1;
  logic [N_BUT-1:0] BUT_LVL, BUT_PRESS, BUT_RELEASE;
  logic             CHORD, TICK;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .N_BUT(N_BUT), .TICK_DIV(TDIV), .DEBOUNCE_TICKS(DEB), .CHORD_LOCKOUT_TICKS(LOCK)
  ) dut (
    .CLK(CLK), .RST(RST), .BUT_N(BUT_N), .BUT_LVL(BUT_LVL), .BUT_PRESS(BUT_PRESS),
    .BUT_RELEASE(BUT_RELEASE), .CHORD(CHORD), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  // Reference model. Cycle n = edges since reset release. A tick is visible in
  // the cycle before edges 5, 9, 13, ...; a change is accepted on the DEB-th tick
  // of an unbroken disagreement; the lockout is the tick count since the last chord.
  int               n = 0;
  int               since [N_BUT];
  int               lock_start = 1;
  logic             armed = 1'b1;
  logic [N_BUT-1:0] r1 = '1, r2 = '1, smp, lvl_pre;
  logic [N_BUT-1:0] m_lvl = '0, m_press = '0, m_rel = '0;
  logic             m_chord = 1'b0, m_tick = 1'b0, tick_pre;

  function automatic int ticks_between(input int a, input int b);
    int lo, hi;
    lo = (a - 1 > int'(TDIV)) ? a - 1 : int'(TDIV);
    hi = b - 1;
    if (hi < lo) return 0;
    return hi / int'(TDIV) - (lo - 1) / int'(TDIV);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      n = 0; r1 = '1; r2 = '1;
      m_lvl = '0; m_press = '0; m_rel = '0; m_chord = 1'b0; m_tick = 1'b0;
      armed = 1'b1; lock_start = 1;
      for (int i = 0; i < int'(N_BUT); i++) since[i] = 1;
    end else begin
      n++;
      tick_pre = m_tick;
      smp = ~r2; r2 = r1; r1 = BUT_N;
      lvl_pre = m_lvl;
      m_press = '0; m_rel = '0;
      for (int i = 0; i < int'(N_BUT); i++) begin
        if (smp[i] == lvl_pre[i]) since[i] = n + 1;
        else if (tick_pre && ticks_between(since[i], n) == int'(DEB)) begin
          m_lvl[i] = smp[i]; m_press[i] = smp[i]; m_rel[i] = ~smp[i]; since[i] = n + 1;
        end
      end
      m_chord = (&lvl_pre) && armed && (ticks_between(lock_start, n - 1) >= int'(LOCK));
      if (m_chord) begin armed = 1'b0; lock_start = n + 1; end
      else if (lvl_pre == '0) armed = 1'b1;
      m_tick = (n % int'(TDIV) == 0);
    end
  end

  logic [7:0] obs, exp_v;
  assign obs   = {BUT_LVL, BUT_PRESS, BUT_RELEASE, CHORD, TICK};
  assign exp_v = {m_lvl, m_press, m_rel, m_chord, m_tick};

  task automatic test_reset();
    int ticks = 0;
    RST = 1'b1; BUT_N = '1;
    repeat (3) @(negedge CLK);
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL reset_state got=%b want=%b", obs, 8'b0); end
    RST = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL reset_model n=%0d got=%b want=%b", n, obs, exp_v); end
      total++; if (TICK !== 1'(c % int'(TDIV) == 0)) begin bad++; $display("FAIL reset_tick c=%0d got=%b want=%b", c, TICK, c % int'(TDIV) == 0); end
      total++; if (obs[7:1] !== 7'b0) begin bad++; $display("FAIL reset_quiet c=%0d got=%b want=0", c, obs[7:1]); end
      if (TICK === 1'b1) ticks++;
    end
    total++; if (ticks != 100 / int'(TDIV)) begin bad++; $display("FAIL reset_tick_count got=%0d want=%0d", ticks, 100 / int'(TDIV)); end
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 60; c++) begin
      if (c < 40 && c % 3 == 0) BUT_N[0] = ~BUT_N[0];
      if (c == 40) BUT_N = '1;
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL glitch_model n=%0d got=%b want=%b", n, obs, exp_v); end
      total++; if (obs[7:2] !== 6'b0) begin bad++; $display("FAIL glitch_quiet c=%0d got=%b want=0", c, obs[7:2]); end
    end
  endtask

  task automatic test_press();
    int rise = -1, npress = 0, nrel = 0;
    repeat ($urandom_range(0, 7)) begin
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL press_pre_model n=%0d got=%b want=%b", n, obs, exp_v); end
    end
    BUT_N[0] = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL press_model n=%0d got=%b want=%b", n, obs, exp_v); end
      if (BUT_LVL[0] === 1'b1 && rise < 0) rise = c;
      if (BUT_PRESS[0] === 1'b1) npress++;
      if (BUT_RELEASE !== 2'b00 || BUT_PRESS[1] !== 1'b0) nrel++;
    end
    total++; if (rise < 0 || rise > 16) begin bad++; $display("FAIL press_latency got=%0d want=1..16", rise); end
    total++; if (npress != 1) begin bad++; $display("FAIL press_strobe_count got=%0d want=1", npress); end
    total++; if (nrel != 0) begin bad++; $display("FAIL press_other_strobes got=%0d want=0", nrel); end
    BUT_N[0] = 1'b1; nrel = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL release_model n=%0d got=%b want=%b", n, obs, exp_v); end
      if (BUT_RELEASE[0] === 1'b1) nrel++;
    end
    total++; if (nrel != 1) begin bad++; $display("FAIL release_strobe_count got=%0d want=1", nrel); end
    total++; if (BUT_LVL !== 2'b00) begin bad++; $display("FAIL release_level got=%b want=00", BUT_LVL); end
  endtask

  task automatic test_chord_reset();
    int both = 0, single = 0, nchord = 0, at = -1;
    RST = 1'b1; BUT_N = 2'b00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL chord_model n=%0d got=%b want=%b", n, obs, exp_v); end
      if (BUT_PRESS === 2'b11) both++;
      if (BUT_PRESS === 2'b01 || BUT_PRESS === 2'b10) single++;
      if (CHORD === 1'b1) begin nchord++; at = c; end
    end
    total++; if (both != 1) begin bad++; $display("FAIL chord_joint_press got=%0d want=1", both); end
    total++; if (single != 0) begin bad++; $display("FAIL chord_split_press got=%0d want=0", single); end
    total++; if (nchord != 1) begin bad++; $display("FAIL chord_count got=%0d want=1", nchord); end
    total++; if (at != int'(LOCK * TDIV + 2)) begin bad++; $display("FAIL chord_time got=%0d want=%0d", at, LOCK * TDIV + 2); end
  endtask

  task automatic test_rechord();
    int c1 = -1, c2 = -1, c3 = -1;
    bit seen;
    RST = 1'b1; BUT_N = 2'b00;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 80 && c1 < 0; k++) begin
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL rechord_model1 n=%0d got=%b want=%b", n, obs, exp_v); end
      if (CHORD === 1'b1) c1 = n;
    end
    total++; if (c1 != int'(LOCK * TDIV + 2)) begin bad++; $display("FAIL rechord_first got=%0d want=%0d", c1, LOCK * TDIV + 2); end
    for (int round = 0; round < 2; round++) begin
      BUT_N = 2'b11; seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge CLK);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL rechord_release_model n=%0d got=%b want=%b", n, obs, exp_v); end
        if (BUT_LVL === 2'b00) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL rechord_release_timeout got=%b want=00", BUT_LVL); end
      BUT_N = 2'b00;
      for (int k = 0; k < 80; k++) begin
        @(negedge CLK);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL rechord_model2 n=%0d got=%b want=%b", n, obs, exp_v); end
        if (CHORD === 1'b1) begin
          if (round == 0) c2 = n; else c3 = n;
          break;
        end
      end
    end
    total++; if (c2 != c1 + int'(LOCK * TDIV)) begin bad++; $display("FAIL rechord_second got=%0d want=%0d", c2, c1 + int'(LOCK * TDIV)); end
    total++; if (c3 != c2 + int'(LOCK * TDIV)) begin bad++; $display("FAIL rechord_third got=%0d want=%0d", c3, c2 + int'(LOCK * TDIV)); end
  endtask

  task automatic test_reset_mid();
    RST = 1'b1; BUT_N = 2'b11;
    repeat (2) @(negedge CLK);
    RST = 1'b0; BUT_N = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL midrst_pre_model n=%0d got=%b want=%b", n, obs, exp_v); end
    end
    RST = 1'b1;
    @(negedge CLK);
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL midrst_clear got=%b want=%b", obs, 8'b0); end
    RST = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL midrst_model n=%0d got=%b want=%b", n, obs, exp_v); end
      if (c == int'(DEB * TDIV)) begin
        total++; if (BUT_LVL[1] !== 1'b0) begin bad++; $display("FAIL midrst_early c=%0d got=%b want=0", c, BUT_LVL[1]); end
      end
      if (c == int'(DEB * TDIV + 1)) begin
        total++; if ({BUT_LVL[1], BUT_PRESS[1]} !== 2'b11) begin bad++; $display("FAIL midrst_accept c=%0d got=%b want=11", c, {BUT_LVL[1], BUT_PRESS[1]}); end
      end
    end
  endtask

  task automatic test_random();
    int hold [N_BUT];
    RST = 1'b1; BUT_N = '1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    hold[0] = 5; hold[1] = 9;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < int'(N_BUT); ch++) begin
        if (hold[ch] == 0) begin
          BUT_N[ch] = ~BUT_N[ch];
          hold[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(10, 40));
        end else hold[ch]--;
      end
      RST = ($urandom_range(0, 499) == 0);
      @(negedge CLK);
      total++; if (obs !== exp_v) begin bad++; $display("FAIL random_model n=%0d got=%b want=%b", n, obs, exp_v); end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_chord_reset();
    test_rechord();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end stage between the board push-buttons (active-low, asynchronous, bouncing) and the LED/mode control logic.
- Synchronises and debounces N buttons on a shared low-rate tick derived from CLK.
- Delivers clean pressed levels, single-cycle press/release strobes, and a rate-limited "all buttons pressed" chord strobe.
- Downstream mode logic needs no debounce counters of its own and runs entirely on CLK.

Parameters:
N_BUT, 2, number of button channels
TICK_DIV, 4096, CLK cycles per sample tick (100 MHz / 4096 ≈ 24.4 kHz); must be ≥2
DEBOUNCE_TICKS, 244, consecutive differing ticks needed to accept a change (≈10 ms); must be ≥1
CHORD_LOCKOUT_TICKS, 16384, minimum ticks between chord strobes, and after reset (≈0.67 s); must be ≥1

Ports:
CLK  input  1  system clock, 100 MHz
RST  input  1  synchronous reset, active-high
BUT_N  input  N_BUT  raw button pins, active-low, asynchronous to CLK
BUT_LVL  output  N_BUT  debounced level, 1 = pressed
BUT_PRESS  output  N_BUT  1-cycle strobe on accepted press
BUT_RELEASE  output  N_BUT  1-cycle strobe on accepted release
CHORD  output  1  1-cycle strobe when all buttons are held, subject to lockout
TICK  output  1  1-cycle sample strobe, exported for downstream timing

Behaviour:
Reset:
- Clock and reset: one clock, CLK; reset is synchronous and active-high (RST). All state is sampled on posedge CLK.
- While RST is 1, on the next edge: sync flops ← 1 (released), BUT_LVL ← 0, BUT_PRESS/BUT_RELEASE/CHORD/TICK ← 0, prescaler ← 0, debounce counters ← 0, lockout counter ← 0, armed ← 1.
- Reset mid-debounce discards partial counts. No strobe is emitted in the cycle following reset deassertion.

Synchroniser:
- Two flops per channel. sample = ~sync2, so 1 = pressed.

Prescaler:
- Counts 0..TICK_DIV-1 and wraps.
- TICK is registered and equals 1 for exactly one cycle each time the count equals TICK_DIV-1. First TICK occurs TICK_DIV cycles after reset release.

Per-channel debounce:
- If sample == BUT_LVL: counter ← 0 on every CLK, not only on ticks.
- Else, on TICK: if counter == DEBOUNCE_TICKS-1, then BUT_LVL ← sample and counter ← 0; otherwise counter ← counter+1.
- BUT_PRESS or BUT_RELEASE is asserted in the same cycle BUT_LVL changes, for 1 cycle, and never both at once.
- Counter width is $clog2(DEBOUNCE_TICKS+1). It never exceeds DEBOUNCE_TICKS-1.
- A glitch shorter than one tick period clears the count. Channels are independent; simultaneous accepts on several channels strobe in the same cycle.

Chord:
- Lockout counter increments on TICK and saturates at CHORD_LOCKOUT_TICKS.
- CHORD fires for 1 cycle when &BUT_LVL == 1, armed == 1, and lockout is saturated. On that same edge: lockout ← 0, armed ← 0.
- armed ← 1 once BUT_LVL == 0 (all released).
- Holding the chord therefore yields exactly one strobe. Re-triggering requires a full release and an expired lockout.
- CHORD is registered from BUT_LVL, so it lags the final BUT_PRESS by 1 cycle.
- A chord reached before lockout expiry fires when lockout saturates, provided it is still held.

Latency:
- Raw edge to BUT_LVL change = 2 sync cycles + DEBOUNCE_TICKS ticks (tick-aligned, so ±1 tick).

Decomposition:
- Package button_pkg holds:
  - default constants CLK_HZ = 100_000_000, TICK_DIV, DEBOUNCE_TICKS, CHORD_LOCKOUT_TICKS;
  - a function deriving DEBOUNCE_TICKS from a millisecond value.
- Sub-module debounce_chan holds one channel: sync flops, counter, level and strobes, with TICK as an input.
- button_conditioner itself holds the prescaler, a generate loop of debounce_chan, and the chord/lockout logic.

Test Plan:
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, CHORD_LOCKOUT_TICKS=8, N_BUT=2.
- Reset release, BUT_N=2'b11 held 100 cycles -> TICK every 4th cycle (first on cycle 4); BUT_LVL=0; no strobes.
- BUT_N[0] driven low cleanly -> BUT_LVL[0]=1 within 2 + 3 ticks (≤16 cycles); BUT_PRESS[0] exactly 1 cycle; BUT_RELEASE stays 0.
- BUT_N[0] toggled every 3 cycles for 40 cycles, then held high -> BUT_LVL[0] never changes; no strobes.
- Both buttons low from reset, held 200 cycles -> both BUT_PRESS strobe in the same cycle; exactly one CHORD, 1 cycle after lockout saturation (tick 8); none while still held.
- Release both, re-press 2 ticks after the first chord -> second CHORD only once 8 ticks have elapsed since the first; then release and re-press immediately -> no CHORD until lockout expires.
- RST asserted mid-debounce, with count at 2 on channel 1 -> all outputs 0 on the next edge; a subsequent press needs a full 3 fresh ticks.
